// File: rtl/barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_pipe
// Description : Pipelined barrel shifter/rotator with one register stage per
//               shift level, valid/ready handshakes, carry/zero flags and tag.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag
);

  localparam logic [2:0] c_SLL = 3'd0;
  localparam logic [2:0] c_SRL = 3'd1;
  localparam logic [2:0] c_SRA = 3'd2;
  localparam logic [2:0] c_ROL = 3'd3;
  localparam logic [2:0] c_ROR = 3'd4;

  logic [SHW-1:0]   r_valid;
  logic [SHW-1:0]   r_carry;
  logic [WIDTH-1:0] r_data [SHW];
  logic [SHW-1:0]   r_amt  [SHW];
  logic [2:0]       r_mode [SHW];
  logic [TAGW-1:0]  r_tag  [SHW];
  logic             r_zero;
  logic [SHW-1:0]   w_ready;

  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_stage
      localparam int c_STEP = 1 << k;

      logic             w_srcValid;
      logic             w_srcCarry;
      logic [WIDTH-1:0] w_srcData;
      logic [SHW-1:0]   w_srcAmt;
      logic [2:0]       w_srcMode;
      logic [TAGW-1:0]  w_srcTag;
      logic [WIDTH-1:0] w_shifted;
      logic [WIDTH-1:0] w_nextData;
      logic             w_nextCarry;

      // A stage can load unless it and every stage below it are occupied.
      assign w_ready[k] = out_ready | ~(&r_valid[SHW-1:k]);

      if (k == 0) begin : g_head
        assign w_srcValid = in_valid;
        assign w_srcCarry = 1'b0;
        assign w_srcData  = in_data;
        assign w_srcAmt   = in_amt;
        assign w_srcMode  = in_mode;
        assign w_srcTag   = in_tag;
      end else begin : g_body
        assign w_srcValid = r_valid[k-1];
        assign w_srcCarry = r_carry[k-1];
        assign w_srcData  = r_data[k-1];
        assign w_srcAmt   = r_amt[k-1];
        assign w_srcMode  = r_mode[k-1];
        assign w_srcTag   = r_tag[k-1];
      end

      // The carry is the last bit pushed out; the highest active level wins.
      always_comb begin
        w_shifted = w_srcData;
        case (w_srcMode)
          c_SLL:   w_shifted = w_srcData << c_STEP;
          c_SRL:   w_shifted = w_srcData >> c_STEP;
          c_SRA:   w_shifted = WIDTH'($signed(w_srcData) >>> c_STEP);
          c_ROL:   w_shifted = {w_srcData[WIDTH-1-c_STEP:0], w_srcData[WIDTH-1:WIDTH-c_STEP]};
          c_ROR:   w_shifted = {w_srcData[c_STEP-1:0], w_srcData[WIDTH-1:c_STEP]};
          default: w_shifted = w_srcData;
        endcase
        w_nextData  = w_srcData;
        w_nextCarry = w_srcCarry;
        if (w_srcAmt[k] && (w_srcMode <= c_ROR)) begin
          w_nextData = w_shifted;
          case (w_srcMode)
            c_SLL:        w_nextCarry = w_srcData[WIDTH-c_STEP];
            c_SRL, c_SRA: w_nextCarry = w_srcData[c_STEP-1];
            c_ROL:        w_nextCarry = w_shifted[0];
            c_ROR:        w_nextCarry = w_shifted[WIDTH-1];
            default:      w_nextCarry = 1'b0;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid[k] <= 1'b0;
          r_carry[k] <= 1'b0;
          r_data[k]  <= '0;
          r_amt[k]   <= '0;
          r_mode[k]  <= '0;
          r_tag[k]   <= '0;
        end else if (w_ready[k]) begin
          r_valid[k] <= w_srcValid;
          r_carry[k] <= w_nextCarry;
          r_data[k]  <= w_nextData;
          r_amt[k]   <= w_srcAmt;
          r_mode[k]  <= w_srcMode;
          r_tag[k]   <= w_srcTag;
        end
      end

      if (k == SHW - 1) begin : g_zero
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_zero <= 1'b0;
          end else if (w_ready[k]) begin
            r_zero <= (w_nextData == '0);
          end
        end
      end
    end
  endgenerate

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_carry = r_carry[SHW-1];
  assign out_zero  = r_zero;
  assign out_tag   = r_tag[SHW-1];

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_shift_pipe
// Description : Self-checking bench for barrel_shift_pipe (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shift_pipe;

  localparam int WIDTH = 32;
  localparam int TAGW  = 4;
  localparam int SHW   = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_mode;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic [TAGW-1:0]  out_tag;

  barrel_shift_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             c;
    logic             z;
    logic [TAGW-1:0]  t;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  res_t q[$];
  int   inflight = 0;
  int   nOut = 0;
  bit   sawFull = 0;
  bit   prevStall = 0;
  res_t prevOut;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Whole-amount reference: shift by n in one step, carry from the original operand.
  function automatic res_t model(input logic [WIDTH-1:0] d, input logic [SHW-1:0] amt,
                                 input logic [2:0] m, input logic [TAGW-1:0] t);
    res_t        res;
    int          n;
    logic [31:0] r;
    logic        c;
    n = int'(amt);
    r = d;
    c = 1'b0;
    case (m)
      3'd0: begin r = d << n; if (n != 0) c = d[32-n]; end
      3'd1: begin r = d >> n; if (n != 0) c = d[n-1]; end
      3'd2: begin r = 32'($signed(d) >>> n); if (n != 0) c = d[n-1]; end
      3'd3: begin r = (d << n) | (d >> (32 - n)); c = (n != 0) && r[0]; end
      3'd4: begin r = (d >> n) | (d << (32 - n)); c = (n != 0) && r[31]; end
      default: ;
    endcase
    res.d = r;
    res.c = c;
    res.z = (r == 32'h0);
    res.t = t;
    return res;
  endfunction

  // Scoreboard monitor, sampling mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      inflight  = 0;
      prevStall = 0;
    end else begin
      if (prevStall)
        checkVal("stall_hold", {out_valid, out_data, out_carry, out_zero, out_tag}, {1'b1, prevOut});
      if (!in_ready) begin
        sawFull = 1;
        checkVal("full_occupancy", 64'(inflight), 64'(SHW));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkVal("extra_out", 64'(out_valid), 64'd0);
        end else begin
          res_t e;
          e = q.pop_front();
          checkVal("sb_result", {out_data, out_carry, out_zero, out_tag}, e);
        end
        nOut++;
        inflight--;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_amt, in_mode, in_tag));
        inflight++;
      end
      prevStall = out_valid && !out_ready;
      prevOut   = {out_data, out_carry, out_zero, out_tag};
    end
  end

  task automatic directed(input string nm, input logic [31:0] d, input int n, input int m,
                          input logic [31:0] ed, input logic ec);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = 5'(n);
    in_mode   = 3'(m);
    in_tag    = 4'(total);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkVal({nm, "_latency"}, 64'(lat), 64'(SHW));
    checkVal({nm, "_data"}, out_data, d == d ? ed : ed);
    checkVal({nm, "_carry"}, out_carry, ec);
    checkVal({nm, "_zero"}, out_zero, ed == 32'h0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] randData();
    case ($urandom % 4)
      0:       return 32'h8000_0000 | 32'($urandom % 16);
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic stream(input int nOps, input bit bpPattern);
    int acc = 0;
    int cyc = 0;
    int startOut;
    bit pending = 0;
    startOut = nOut;
    while (acc < nOps && cyc < 20000) begin
      @(posedge clk); #1;
      out_ready = bpPattern ? !(cyc >= 3 && cyc <= 10) : 1'($urandom % 2);
      if (!pending) begin
        in_data = randData();
        in_amt  = 5'($urandom);
        in_mode = 3'($urandom);
        in_tag  = 4'($urandom);
      end
      in_valid = (bpPattern || pending) ? 1'b1 : 1'($urandom % 2);
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc++;
        pending = 0;
      end else begin
        pending = in_valid;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    checkVal("stream_accepted", 64'(acc), 64'(nOps));
    checkVal("stream_drained", 64'(q.size()), 64'd0);
    checkVal("stream_count", 64'(nOut - startOut), 64'(nOps));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    checkVal("reset_outputs", {out_valid, out_data, out_carry, out_zero, out_tag, in_ready},
             {1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1});
    @(posedge clk); #3;
    rst_n = 1'b1;

    directed("sll1",    32'h8000_0001, 1, 0, 32'h0000_0002, 1'b1);
    directed("sll_zero",32'h8000_0000, 1, 0, 32'h0000_0000, 1'b1);
    directed("sra31",   32'h8000_0000, 31, 2, 32'hFFFF_FFFF, 1'b0);
    directed("srl31",   32'h8000_0000, 31, 1, 32'h0000_0001, 1'b0);
    directed("srl1",    32'h0000_0003, 1, 1, 32'h0000_0001, 1'b1);
    directed("rol1",    32'h8000_0000, 1, 3, 32'h0000_0001, 1'b1);
    directed("ror4",    32'h0000_0001, 4, 4, 32'h1000_0000, 1'b0);
    directed("ror1",    32'h0000_0001, 1, 4, 32'h8000_0000, 1'b1);
    directed("sll31",   32'h0000_0003, 31, 0, 32'h8000_0000, 1'b1);
    directed("mode6",   32'hDEAD_BEEF, 7, 6, 32'hDEAD_BEEF, 1'b0);
    for (int m = 0; m < 8; m++) begin
      logic [31:0] d;
      d = $urandom | 32'h8000_0001;
      directed($sformatf("amt0_mode%0d", m), d, 0, m, d, 1'b0);
    end

    sawFull = 0;
    stream(20, 1'b1);
    checkVal("bp_filled", 64'(sawFull), 64'd1);

    stream(2000, 1'b0);

    // Reset with three ops in flight, the oldest parked at the output.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1234_5670 + 32'(i);
      in_amt   = 5'd0;
      in_mode  = 3'd5;
      in_tag   = 4'hA;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkVal("pre_reset_valid", {out_valid, out_data, out_tag}, {1'b1, 32'h1234_5670, 4'hA});
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async_reset", {out_valid, out_data, out_carry, out_zero, out_tag, in_ready},
             {1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1});
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    checkVal("post_reset", {out_valid, in_ready}, {1'b0, 1'b1});
    directed("after_reset", 32'h0000_00F0, 4, 1, 32'h0000_000F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
